// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package smitrv_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// Watchdog for a BUSY memory transaction; built only with MEM_ARB_TIMEOUT_EN.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_timeout_ctr #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic ack,
    output logic expire
);
    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic          armed;
    logic [CW-1:0] cnt;

    // Fires during the LIMIT-th BUSY cycle without an ack; a same-cycle ack wins.
    assign expire = armed && !ack && (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            armed <= 1'b0;
            cnt   <= '0;
        end else if (start) begin
            armed <= 1'b1;
            cnt   <= '0;
        end else if (armed) begin
            if (ack || expire) begin
                armed <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one handshaked memory port.
// Optional watchdog abort enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import smitrv_mem_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned RR_EN          = 0,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                err
);
    state_t state, state_next;
    owner_t owner, last_owner, grant_owner;
    logic   grant, done, abort, expire;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_timeout_ctr #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .start (grant),
        .ack   (mem_ack),
        .expire(expire)
    );
`else
    localparam int unsigned timeout_unused = TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        grant       = 1'b0;
        grant_owner = OWN_D;
        done        = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    grant      = 1'b1;
                    state_next = BUSY;
                    if (if_req && d_req) begin
                        // Round-robin hands a conflict to whoever did not own the last grant.
                        grant_owner = (RR_EN != 0 && last_owner == OWN_D) ? OWN_IF : OWN_D;
                    end else begin
                        grant_owner = d_req ? OWN_D : OWN_IF;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (expire) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= OWN_D;
            last_owner <= OWN_D;
            if_gnt     <= 1'b0;
            d_gnt      <= 1'b0;
            if_rvalid  <= 1'b0;
            d_rvalid   <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            err        <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            err       <= 1'b0;
            if (grant) begin
                owner      <= grant_owner;
                last_owner <= grant_owner;
                mem_req    <= 1'b1;
                if (grant_owner == OWN_D) begin
                    d_gnt     <= 1'b1;
                    mem_we    <= d_we;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                    mem_be    <= d_be;
                end else begin
                    if_gnt    <= 1'b1;
                    mem_we    <= 1'b0;
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                    mem_be    <= '1;
                end
            end
            if (done || abort) begin
                mem_req <= 1'b0;
                err     <= abort;
                if (owner == OWN_D) begin
                    d_rvalid <= 1'b1;
                    if (abort) begin
                        d_rdata <= DATA_W'(TIMEOUT_DATA);
                    end else if (!mem_we) begin
                        d_rdata <= mem_rdata;
                    end
                end else begin
                    if_rvalid <= 1'b1;
                    if_rdata  <= abort ? DATA_W'(TIMEOUT_DATA) : mem_rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fixed-priority instance plus a round-robin instance.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, err;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        r_if_req, r_d_req, r_mem_ack, rr_go;
    logic [31:0] r_zero32 = 32'h0;
    logic [3:0]  r_zero4  = 4'h0;
    logic        r_if_gnt, r_if_rvalid, r_d_gnt, r_d_rvalid, r_mem_req, r_mem_we, r_err;
    logic [31:0] r_if_rdata, r_d_rdata, r_mem_addr, r_mem_wdata;
    logic [3:0]  r_mem_be;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [31:0] exp_if_rd, exp_d_rd;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    // Zero-wait memory for the round-robin instance: acks in the first mem_req cycle.
    assign r_mem_ack = r_mem_req & rr_go;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1), .TIMEOUT_CYCLES(16)) dut_rr (
        .clk(clk), .reset(reset),
        .if_req(r_if_req), .if_addr(r_zero32), .if_gnt(r_if_gnt), .if_rvalid(r_if_rvalid), .if_rdata(r_if_rdata),
        .d_req(r_d_req), .d_we(1'b0), .d_addr(r_zero32), .d_wdata(r_zero32), .d_be(r_zero4),
        .d_gnt(r_d_gnt), .d_rvalid(r_d_rvalid), .d_rdata(r_d_rdata),
        .mem_req(r_mem_req), .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata), .mem_be(r_mem_be),
        .mem_rdata(r_zero32), .mem_ack(r_mem_ack), .err(r_err)
    );

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] mrdata;
        int unsigned delay;
        logic        exp_we;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
            d_we = 1'b1; d_wdata = 32'h5555AAAA; d_be = 4'h0; d_addr = 32'hFFFF0000;
        end
        @(negedge clk);
        chk("gnt_own", v.is_d ? d_gnt : if_gnt, 1'b1);
        chk("gnt_other", v.is_d ? if_gnt : d_gnt, 1'b0);
        chk("mem_req", mem_req, 1'b1);
        chk("mem_addr", mem_addr, v.addr);
        chk("mem_we", mem_we, v.exp_we);
        chk("mem_wdata", mem_wdata, v.exp_wdata);
        chk("mem_be", mem_be, v.exp_be);
        chk("err_idle", err, 1'b0);
        if_req = 1'b0; d_req = 1'b0; d_wdata = 32'h0BAD0BAD; d_addr = 32'h0; d_be = 4'h0;
        for (int i = 0; i < int'(v.delay); i++) begin
            @(negedge clk);
            chk("hold_req", mem_req, 1'b1);
            chk("hold_addr", mem_addr, v.addr);
            chk("hold_wdata", mem_wdata, v.exp_wdata);
            chk("no_early_rvalid", if_rvalid | d_rvalid, 1'b0);
        end
        mem_ack = 1'b1; mem_rdata = v.mrdata;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 32'h0;
        chk("rvalid_own", v.is_d ? d_rvalid : if_rvalid, 1'b1);
        chk("rvalid_other", v.is_d ? if_rvalid : d_rvalid, 1'b0);
        chk("rdata_own", v.is_d ? d_rdata : if_rdata, v.exp_rdata);
        chk("rdata_other", v.is_d ? if_rdata : d_rdata, v.is_d ? exp_if_rd : exp_d_rd);
        chk("mem_req_drop", mem_req, 1'b0);
        if (v.is_d) exp_d_rd = v.exp_rdata; else exp_if_rd = v.exp_rdata;
        @(negedge clk);
        chk("rvalid_single", if_rvalid | d_rvalid, 1'b0);
    endtask

    initial begin
        int unsigned n, ngr, last_t, t, both;
        logic        ord[4];

        vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        4'h0, 32'h00500093, 2, 1'b0, 32'h0,        4'hF, 32'h00500093};
        vecs[1] = '{1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 4'h3, 32'h11111111, 1, 1'b1, 32'hCAFEF00D, 4'h3, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h204, 32'h99999999, 4'hF, 32'h12345678, 0, 1'b0, 32'h99999999, 4'hF, 32'h12345678};
        vecs[3] = '{1'b1, 1'b1, 32'h208, 32'hAABBCCDD, 4'hC, 32'h22222222, 0, 1'b1, 32'hAABBCCDD, 4'hC, 32'h12345678};
        vecs[4] = '{1'b0, 1'b0, 32'h104, 32'h0,        4'h0, 32'h00A00113, 3, 1'b0, 32'h0,        4'hF, 32'h00A00113};

        reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;
        r_if_req = 1'b0; r_d_req = 1'b0; rr_go = 1'b0;
        exp_if_rd = '0; exp_d_rd = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_pulses", {28'h0, if_gnt, d_gnt, if_rvalid, d_rvalid}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
        chk("rst_rdata", if_rdata | d_rdata, 32'h0);
        chk("rst_err", err, 1'b0);
        reset = 1'b0;

        // Stray ack while idle must be ignored.
        @(negedge clk); mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk); mem_ack = 1'b0;
        chk("stray_ack_rvalid", if_rvalid | d_rvalid, 1'b0);
        chk("stray_ack_rdata", if_rdata, 32'h0);

        for (int k = 0; k < 5; k++) run_vec(vecs[k]);

        // Fixed priority: data always wins, fetch follows after data completes.
        for (int rep = 0; rep < 3; rep++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'h400 + 32'(rep * 4);
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500 + 32'(rep * 4); d_be = 4'hF; d_wdata = '0;
            @(negedge clk);
            chk("fp_d_first", d_gnt, 1'b1);
            chk("fp_if_wait", if_gnt, 1'b0);
            chk("fp_d_addr", mem_addr, 32'h500 + 32'(rep * 4));
            d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hD0000000 + 32'(rep);
            @(negedge clk);
            mem_ack = 1'b0;
            chk("fp_d_rvalid", d_rvalid, 1'b1);
            chk("fp_d_rdata", d_rdata, 32'hD0000000 + 32'(rep));
            chk("fp_if_not_yet", if_gnt, 1'b0);
            @(negedge clk);
            chk("fp_if_gnt", if_gnt, 1'b1);
            chk("fp_if_addr", mem_addr, 32'h400 + 32'(rep * 4));
            if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h10000000 + 32'(rep);
            @(negedge clk);
            mem_ack = 1'b0;
            chk("fp_if_rvalid", if_rvalid, 1'b1);
            chk("fp_if_rdata", if_rdata, 32'h10000000 + 32'(rep));
        end

        // Reset while BUSY, followed by a late ack.
        @(negedge clk); if_req = 1'b1; if_addr = 32'h600;
        @(negedge clk); chk("rb_gnt", if_gnt, 1'b1); if_req = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk("rb_mem_req", mem_req, 1'b0);
        chk("rb_pulses", {28'h0, if_gnt, d_gnt, if_rvalid, d_rvalid}, 32'h0);
        chk("rb_mem_addr", mem_addr, 32'h0);
        chk("rb_rdata", if_rdata | d_rdata, 32'h0);
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77777777;
        @(negedge clk); mem_ack = 1'b0;
        chk("rb_late_ack", if_rvalid | d_rvalid, 1'b0);
        chk("rb_late_req", mem_req, 1'b0);
        exp_if_rd = '0; exp_d_rd = '0;

        // Round-robin: continuous conflict must alternate, fetch first after reset.
        @(negedge clk); r_if_req = 1'b1; r_d_req = 1'b1; rr_go = 1'b1;
        ngr = 0; last_t = 0; t = 0; both = 0;
        while (ngr < 4 && t < 40) begin
            @(negedge clk); t++;
            if ((r_if_gnt && r_d_gnt) || (r_if_rvalid && r_d_rvalid)) both = 1;
            if (r_if_gnt || r_d_gnt) begin
                ord[ngr] = r_d_gnt;
                if (ngr > 0) chk("rr_gap", t - last_t, 2);
                last_t = t;
                ngr++;
            end
        end
        r_if_req = 1'b0; r_d_req = 1'b0;
        chk("rr_count", ngr, 4);
        chk("rr_excl", both, 0);
        for (int g = 0; g < 4; g++) begin
            if (g < int'(ngr)) chk("rr_order", {31'h0, ord[g]}, (g % 2 == 1) ? 32'h1 : 32'h0);
        end
        repeat (3) @(negedge clk);
        rr_go = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
        @(negedge clk); if_req = 1'b1; if_addr = 32'h300;
        @(negedge clk); chk("to_gnt", if_gnt, 1'b1); if_req = 1'b0;
        n = 0;
        while (mem_req && n < 40) begin
            chk("to_no_err", err, 1'b0);
            @(negedge clk); n++;
        end
        chk("to_busy_cycles", n, 16);
        chk("to_err", err, 1'b1);
        chk("to_rvalid", if_rvalid, 1'b1);
        chk("to_rdata", if_rdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("to_err_pulse", err, 1'b0);
        exp_if_rd = 32'hDEADBEEF;
        run_vec(vecs[0]);
`else
        chk("no_to_err", err | r_err, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
